// File: rtl/rtc_calendar_alarm_if.sv
// Control, load, alarm and time-of-day signals of the calendar counter.
// The testbench or controller drives the master side and the calendar drives the slave side.
// All signals are plain levels or one-cycle pulses with no handshake.
interface rtc_calendar_alarm_if #(
  parameter int YEAR_W = 6
);
  // run control
  logic              start;
  logic              stop;
  // synchronous field load
  logic              load;
  logic [YEAR_W-1:0] ld_year;
  logic [3:0]        ld_month;
  logic [4:0]        ld_day;
  logic [4:0]        ld_hour;
  logic [5:0]        ld_minute;
  logic [5:0]        ld_second;
  // daily alarm
  logic              alarm_en;
  logic [4:0]        al_hour;
  logic [5:0]        al_minute;
  logic [5:0]        al_second;
  // current time and status
  logic [YEAR_W-1:0] year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [4:0]        hour;
  logic [5:0]        minute;
  logic [5:0]        second;
  logic              running;
  logic              tick_sec;
  logic              alarm;
  logic              load_err;

  modport master (
    output start, stop, load,
    output ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second,
    output alarm_en, al_hour, al_minute, al_second,
    input  year, month, day, hour, minute, second,
    input  running, tick_sec, alarm, load_err
  );

  modport slave (
    input  start, stop, load,
    input  ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second,
    input  alarm_en, al_hour, al_minute, al_second,
    output year, month, day, hour, minute, second,
    output running, tick_sec, alarm, load_err
  );
endinterface

// File: rtl/rtc_calendar_alarm.sv
// Real-time calendar: start/stop, prescaled second advance, leap-aware date cascade, daily alarm.
// Latency: every output is registered and updates one clk after the triggering edge.
// No backpressure: start/stop are levels, load is a one-cycle request that is accepted or flagged.
module rtc_calendar_alarm #(
  parameter int TICKS_PER_SEC = 1,
  parameter int YEAR_W        = 6   // at least 2: leap detection uses year[1:0]
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rtc_calendar_alarm_if.slave   bus_if
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [3:0]        month_q, month_d;
  logic [4:0]        day_q, day_d;
  logic [4:0]        hour_q, hour_d;
  logic [5:0]        minute_q, minute_d;
  logic [5:0]        second_q, second_d;
  logic              running_q, running_d;
  logic              tick_q, tick_d;
  logic              alarm_q, alarm_d;
  logic              load_err_q, load_err_d;

  logic              run_en;
  logic              presc_wrap;
  logic              ld_ok;
  logic              load_acc;
  logic              adv;
  logic [4:0]        dim_cur;
  logic [4:0]        dim_ld;
  logic              c_sec, c_min, c_hour, c_day, c_month;

  // Month length; February gains a day whenever the low two year bits are zero.
  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [1:0] yr_lo);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (yr_lo == 2'd0) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // Run/stop next state: stop always wins over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (bus_if.start && !bus_if.stop) state_d = ST_RUN;
      ST_RUN:  if (bus_if.stop)                  state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // Load validation and advance qualification; a stop seen this cycle blocks the advance.
  always_comb begin
    dim_cur    = days_in_month(month_q, year_q[1:0]);
    dim_ld     = days_in_month(bus_if.ld_month, bus_if.ld_year[1:0]);
    run_en     = (state_q == ST_RUN) && !bus_if.stop;
    presc_wrap = run_en && (presc_q == PRESC_MAX);
    ld_ok      = (bus_if.ld_month >= 4'd1) && (bus_if.ld_month <= 4'd12) &&
                 (bus_if.ld_day   >= 5'd1) && (bus_if.ld_day   <= dim_ld) &&
                 (bus_if.ld_hour   <= 5'd23) &&
                 (bus_if.ld_minute <= 6'd59) &&
                 (bus_if.ld_second <= 6'd59);
    load_acc   = bus_if.load && ld_ok;
    adv        = presc_wrap && !load_acc;
    c_sec      = (second_q == 6'd59);
    c_min      = c_sec  && (minute_q == 6'd59);
    c_hour     = c_min  && (hour_q == 5'd23);
    c_day      = c_hour && (day_q >= dim_cur);
    c_month    = c_day  && (month_q == 4'd12);
  end

  // Next time fields: an accepted load overrides the advance; otherwise carry through the cascade.
  always_comb begin
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    presc_d  = presc_q;
    if (load_acc) begin
      year_d   = bus_if.ld_year;
      month_d  = bus_if.ld_month;
      day_d    = bus_if.ld_day;
      hour_d   = bus_if.ld_hour;
      minute_d = bus_if.ld_minute;
      second_d = bus_if.ld_second;
      presc_d  = '0;
    end else begin
      if (run_en) presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      if (adv) begin
        second_d = c_sec ? 6'd0 : second_q + 6'd1;
        if (c_sec)   minute_d = c_min ? 6'd0 : minute_q + 6'd1;
        if (c_min)   hour_d   = c_hour ? 5'd0 : hour_q + 5'd1;
        if (c_hour)  day_d    = c_day ? 5'd1 : day_q + 5'd1;
        if (c_day)   month_d  = c_month ? 4'd1 : month_q + 4'd1;
        if (c_month) year_d   = year_q + YEAR_W'(1);
      end
    end
  end

  // Status pulses; the alarm looks at the post-advance time so it coincides with the matching output.
  always_comb begin
    running_d  = (state_d == ST_RUN);
    tick_d     = adv;
    load_err_d = bus_if.load && !ld_ok;
    alarm_d    = adv && bus_if.alarm_en &&
                 (hour_d   == bus_if.al_hour) &&
                 (minute_d == bus_if.al_minute) &&
                 (second_d == bus_if.al_second);
  end

  // Run/stop state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_STOP;
    else         state_q <= state_d;
  end

  // Time, prescaler and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      year_q     <= '0;
      month_q    <= 4'd1;
      day_q      <= 5'd1;
      hour_q     <= 5'd0;
      minute_q   <= 6'd0;
      second_q   <= 6'd0;
      running_q  <= 1'b0;
      tick_q     <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      running_q  <= running_d;
      tick_q     <= tick_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus_if.year     = year_q;
  assign bus_if.month    = month_q;
  assign bus_if.day      = day_q;
  assign bus_if.hour     = hour_q;
  assign bus_if.minute   = minute_q;
  assign bus_if.second   = second_q;
  assign bus_if.running  = running_q;
  assign bus_if.tick_sec = tick_q;
  assign bus_if.alarm    = alarm_q;
  assign bus_if.load_err = load_err_q;

endmodule

// File: tb/tb_rtc_calendar_alarm.sv
// Directed bench for the calendar counter: one instance at one tick per second, one prescaled by four.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
// Expected values are hand-derived constants.
module tb_rtc_calendar_alarm;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rtc_calendar_alarm_if #(.YEAR_W(6)) a_if ();
  rtc_calendar_alarm_if #(.YEAR_W(6)) b_if ();

  rtc_calendar_alarm #(.TICKS_PER_SEC(1), .YEAR_W(6)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .bus_if(a_if.slave)
  );
  rtc_calendar_alarm #(.TICKS_PER_SEC(4), .YEAR_W(6)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .bus_if(b_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tp(input logic [5:0] y, input logic [3:0] mo, input logic [4:0] d,
                                     input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
    return {y, mo, d, h, mi, s};
  endfunction

  function automatic logic [31:0] a_now();
    return {a_if.year, a_if.month, a_if.day, a_if.hour, a_if.minute, a_if.second};
  endfunction

  function automatic logic [31:0] b_now();
    return {b_if.year, b_if.month, b_if.day, b_if.hour, b_if.minute, b_if.second};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [5:0] y, input logic [3:0] mo, input logic [4:0] d,
                        input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
    a_if.ld_year = y; a_if.ld_month = mo; a_if.ld_day = d;
    a_if.ld_hour = h; a_if.ld_minute = mi; a_if.ld_second = s;
    a_if.load = 1'b1;
    step(1);
    a_if.load = 1'b0;
  endtask

  // start edge, one advance edge, then a stop edge: exactly one second elapses
  task automatic one_sec_a();
    a_if.start = 1'b1;
    step(1);
    a_if.start = 1'b0;
    step(1);
    a_if.stop = 1'b1;
    step(1);
    a_if.stop = 1'b0;
  endtask

  initial begin
    a_if.start = 0; a_if.stop = 0; a_if.load = 0;
    a_if.ld_year = 0; a_if.ld_month = 0; a_if.ld_day = 0;
    a_if.ld_hour = 0; a_if.ld_minute = 0; a_if.ld_second = 0;
    a_if.alarm_en = 0; a_if.al_hour = 0; a_if.al_minute = 0; a_if.al_second = 0;
    b_if.start = 0; b_if.stop = 0; b_if.load = 0;
    b_if.ld_year = 0; b_if.ld_month = 0; b_if.ld_day = 0;
    b_if.ld_hour = 0; b_if.ld_minute = 0; b_if.ld_second = 0;
    b_if.alarm_en = 0; b_if.al_hour = 0; b_if.al_minute = 0; b_if.al_second = 0;

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("reset_time_a", a_now(), tp(0, 1, 1, 0, 0, 0));
    chk("reset_time_b", b_now(), tp(0, 1, 1, 0, 0, 0));
    chk("reset_status_a", {28'd0, a_if.running, a_if.tick_sec, a_if.alarm, a_if.load_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // start at one tick per second
    a_if.start = 1'b1;
    step(1);
    a_if.start = 1'b0;
    chk("start_running", a_if.running, 1);
    chk("start_sec0", a_if.second, 0);
    step(1);
    chk("first_sec", {a_if.tick_sec, a_if.second}, {1'b1, 6'd1});
    step(4);
    chk("fifth_sec", {a_if.tick_sec, a_if.second}, {1'b1, 6'd5});
    a_if.stop = 1'b1;
    step(1);
    a_if.stop = 1'b0;
    chk("stop_holds_a", {a_if.running, a_if.tick_sec, a_if.second}, {1'b0, 1'b0, 6'd5});

    // prescaler of four, stop freezes and resume continues
    b_if.start = 1'b1;
    step(1);
    b_if.start = 1'b0;
    step(3);
    chk("presc_pre", b_if.second, 0);
    step(1);
    chk("presc_first", {b_if.tick_sec, b_if.second}, {1'b1, 6'd1});
    step(2);
    chk("presc_tick_low", b_if.tick_sec, 0);
    b_if.stop = 1'b1;
    step(1);
    b_if.stop = 1'b0;
    chk("presc_stopped", b_if.running, 0);
    step(10);
    chk("presc_frozen", b_if.second, 1);
    b_if.start = 1'b1;
    step(1);
    b_if.start = 1'b0;
    step(1);
    chk("resume_1edge", b_if.second, 1);
    step(1);
    chk("resume_2edge", b_if.second, 2);
    b_if.stop = 1'b1;
    step(1);
    b_if.start = 1'b1;
    step(3);
    chk("start_stop_both", {b_if.running, b_if.second}, {1'b0, 6'd2});
    b_if.start = 1'b0; b_if.stop = 1'b0;
    step(2);
    chk("still_stopped", b_if.running, 0);

    // rollover
    load_a(3, 12, 31, 23, 59, 59);
    chk("load_ok", {a_if.load_err, a_now()}, {1'b0, tp(3, 12, 31, 23, 59, 59)});
    one_sec_a();
    chk("year_roll", a_now(), tp(4, 1, 1, 0, 0, 0));
    load_a(63, 12, 31, 23, 59, 59);
    one_sec_a();
    chk("year_wrap", a_now(), tp(0, 1, 1, 0, 0, 0));

    // leap years
    load_a(4, 2, 28, 23, 59, 59);
    one_sec_a();
    chk("leap_feb29", a_now(), tp(4, 2, 29, 0, 0, 0));
    load_a(5, 2, 28, 23, 59, 59);
    one_sec_a();
    chk("nonleap_mar1", a_now(), tp(5, 3, 1, 0, 0, 0));
    load_a(4, 2, 29, 23, 59, 59);
    one_sec_a();
    chk("leap_mar1", a_now(), tp(4, 3, 1, 0, 0, 0));
    load_a(4, 4, 30, 23, 59, 59);
    one_sec_a();
    chk("apr30_may1", a_now(), tp(4, 5, 1, 0, 0, 0));

    // invalid loads
    load_a(5, 2, 29, 0, 0, 0);
    chk("bad_feb29_err", {a_if.load_err, a_now()}, {1'b1, tp(4, 5, 1, 0, 0, 0)});
    step(1);
    chk("err_one_cycle", a_if.load_err, 0);
    load_a(5, 13, 1, 0, 0, 0);
    chk("bad_month_err", {a_if.load_err, a_now()}, {1'b1, tp(4, 5, 1, 0, 0, 0)});
    load_a(5, 1, 1, 24, 0, 0);
    chk("bad_hour_err", {a_if.load_err, a_now()}, {1'b1, tp(4, 5, 1, 0, 0, 0)});
    load_a(5, 6, 31, 0, 0, 0);
    chk("bad_jun31_err", {a_if.load_err, a_now()}, {1'b1, tp(4, 5, 1, 0, 0, 0)});

    // load coincident with advance
    a_if.start = 1'b1;
    step(1);
    a_if.start = 1'b0;
    load_a(10, 6, 15, 12, 30, 45);
    chk("load_beats_adv", {a_if.tick_sec, a_now()}, {1'b0, tp(10, 6, 15, 12, 30, 45)});
    step(1);
    chk("adv_after_load", {a_if.tick_sec, a_now()}, {1'b1, tp(10, 6, 15, 12, 30, 46)});
    a_if.stop = 1'b1;
    step(1);
    a_if.stop = 1'b0;

    // alarm
    a_if.alarm_en = 1'b1;
    a_if.al_hour = 0; a_if.al_minute = 0; a_if.al_second = 10;
    load_a(0, 1, 1, 0, 0, 8);
    chk("alarm_not_on_load8", a_if.alarm, 0);
    a_if.start = 1'b1;
    step(1);
    a_if.start = 1'b0;
    step(1);
    chk("alarm_sec9", {a_if.alarm, a_if.second}, {1'b0, 6'd9});
    step(1);
    chk("alarm_sec10", {a_if.alarm, a_if.second}, {1'b1, 6'd10});
    step(1);
    chk("alarm_sec11", {a_if.alarm, a_if.second}, {1'b0, 6'd11});
    a_if.stop = 1'b1;
    step(1);
    a_if.stop = 1'b0;
    load_a(0, 1, 1, 0, 0, 10);
    chk("alarm_not_on_load10", {a_if.alarm, a_if.second}, {1'b0, 6'd10});

    // asynchronous reset mid-run
    a_if.start = 1'b1;
    step(1);
    a_if.start = 1'b0;
    step(2);
    chk("prerst_running", {a_if.running, a_if.second}, {1'b1, 6'd12});
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_time", a_now(), tp(0, 1, 1, 0, 0, 0));
    chk("async_rst_status", {28'd0, a_if.running, a_if.tick_sec, a_if.alarm, a_if.load_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3);
    chk("post_rst_idle", {a_if.running, a_if.second}, {1'b0, 6'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
